// File: rtl/req_arbiter16_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | req_arbiter16_if : request/grant bundle between requesters and the  |
// | arbiter.  Rev 1.0                                                   |
// +--------------------------------------------------------------------+
interface req_arbiter16_if #(
    parameter int N   = 16,
    parameter int IDW = 4
);
    logic [N-1:0]   req;
    logic           mode;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           preempt;

    modport master (
        output req, mode,
        input  gnt, gnt_id, gnt_valid, preempt
    );

    modport slave (
        input  req, mode,
        output gnt, gnt_id, gnt_valid, preempt
    );
endinterface
`default_nettype wire

// File: rtl/req_arbiter16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | req_arbiter16 : N-way fixed-priority / round-robin arbiter with     |
// | grant hold and optional hold timeout.  Rev 1.0                      |
// +--------------------------------------------------------------------+
module req_arbiter16 #(
    parameter int N        = 16,
    parameter int IDW      = 4,
    parameter int MAX_HOLD = 0,
    parameter int CW       = 8
) (
    input  logic            clk,
    input  logic            rst,
    req_arbiter16_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [IDW-1:0] C_LAST_ID = IDW'(N - 1);
    localparam logic [N-1:0]   C_ONE     = {{(N-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_nx;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_cnt;
    logic           r_preempt;

    logic [IDW-1:0] w_gnt_id_nx;
    logic [IDW-1:0] w_ptr_nx;
    logic [CW-1:0]  w_cnt_nx;
    logic           w_preempt_nx;
    logic           w_valid_nx;

    logic [N-1:0]   w_mask;
    logic           w_owner_req;
    logic           w_timeout;
    logic           w_fp_any;
    logic [IDW-1:0] w_fp_id;
    logic           w_hi_any;
    logic [IDW-1:0] w_hi_id;
    logic           w_win_any;
    logic [IDW-1:0] w_win_id;

    // r_gnt is zero in IDLE, so this is the raw request vector there
    assign w_mask      = bus.req & ~r_gnt;
    assign w_owner_req = |(bus.req & r_gnt);
    assign w_timeout   = (MAX_HOLD != 0) && (r_cnt == CW'(MAX_HOLD));

    // Downward scan: the last hit is the lowest index. Round-robin takes the
    // lowest hit at or above ptr, otherwise wraps to the lowest overall.
    always_comb begin
        w_fp_any = 1'b0;
        w_fp_id  = '0;
        w_hi_any = 1'b0;
        w_hi_id  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_mask[i]) begin
                w_fp_any = 1'b1;
                w_fp_id  = IDW'(i);
                if (IDW'(i) >= r_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_id  = IDW'(i);
                end
            end
        end
        w_win_any = w_fp_any;
        w_win_id  = (bus.mode && w_hi_any) ? w_hi_id : w_fp_id;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_gnt_id_nx  = r_gnt_id;
        w_ptr_nx     = r_ptr;
        w_cnt_nx     = r_cnt;
        w_preempt_nx = 1'b0;
        w_valid_nx   = (r_state == BUSY);
        case (r_state)
            IDLE: begin
                if (w_win_any) begin
                    w_state_nx  = BUSY;
                    w_valid_nx  = 1'b1;
                    w_gnt_id_nx = w_win_id;
                    w_cnt_nx    = CW'(1);
                    w_ptr_nx    = (w_win_id == C_LAST_ID) ? '0 : w_win_id + IDW'(1);
                end else begin
                    w_gnt_id_nx = '0;
                end
            end
            BUSY: begin
                if (w_owner_req && !w_timeout) begin
                    // Timeout fires at MAX_HOLD, so the count never passes it
                    if (MAX_HOLD != 0) begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end else if (w_win_any) begin
                    w_gnt_id_nx  = w_win_id;
                    w_cnt_nx     = CW'(1);
                    w_ptr_nx     = (w_win_id == C_LAST_ID) ? '0 : w_win_id + IDW'(1);
                    w_preempt_nx = w_owner_req;
                end else if (w_owner_req) begin
                    w_cnt_nx = CW'(1);
                    w_ptr_nx = (r_gnt_id == C_LAST_ID) ? '0 : r_gnt_id + IDW'(1);
                end else begin
                    w_state_nx  = IDLE;
                    w_valid_nx  = 1'b0;
                    w_gnt_id_nx = '0;
                    w_cnt_nx    = '0;
                end
            end
            default: begin
                w_state_nx  = IDLE;
                w_valid_nx  = 1'b0;
                w_gnt_id_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_gnt     <= w_valid_nx ? (C_ONE << w_gnt_id_nx) : '0;
            r_gnt_id  <= w_gnt_id_nx;
            r_ptr     <= w_ptr_nx;
            r_cnt     <= w_cnt_nx;
            r_preempt <= w_preempt_nx;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = (r_state == BUSY);
    assign bus.preempt   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_req_arbiter16 : directed scoreboard bench for req_arbiter16      |
// | (MAX_HOLD=4).  Rev 1.0                                              |
// +--------------------------------------------------------------------+
module tb_req_arbiter16;

    typedef struct {
        logic [15:0] gnt;
        logic [3:0]  id;
        logic        valid;
        logic        pre;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    req_arbiter16_if #(.N(16), .IDW(4)) bus ();

    req_arbiter16 #(
        .N        (16),
        .IDW      (4),
        .MAX_HOLD (4),
        .CW       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue what the
    // outputs must be after the following rising edge (id < 0: no grant).
    task automatic step(input logic r, input logic [15:0] rq, input logic md,
                        input int id, input logic pre, input string nm);
        exp_t e;
        @(negedge clk);
        rst      = r;
        bus.req  = rq;
        bus.mode = md;
        e.valid  = (id >= 0);
        e.id     = (id >= 0) ? 4'(id) : 4'd0;
        e.gnt    = (id >= 0) ? (16'd1 << id) : 16'd0;
        e.pre    = pre;
        e.name   = nm;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (bus.gnt !== e.gnt || bus.gnt_id !== e.id ||
                bus.gnt_valid !== e.valid || bus.preempt !== e.pre) begin
                failures++;
                $display("FAIL %s: got gnt=%h gnt_id=%0d valid=%b preempt=%b, want gnt=%h gnt_id=%0d valid=%b preempt=%b",
                         e.name, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt,
                         e.gnt, e.id, e.valid, e.pre);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, pending=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        bus.req  = '0;
        bus.mode = 1'b0;

        // Reset, idle, first grant
        step(1, 16'h0000, 0, -1, 0, "rst_a");
        step(1, 16'h0000, 0, -1, 0, "rst_b");
        for (int i = 0; i < 3; i++) step(0, 16'h0000, 0, -1, 0, "idle");
        step(0, 16'h0090, 0, 4, 0, "first_grant");
        step(0, 16'h0000, 0, -1, 0, "first_release");

        // Fixed priority with back-to-back release
        step(0, 16'h8421, 0, 0,  0, "fp_0");
        step(0, 16'h8420, 0, 5,  0, "fp_5");
        step(0, 16'h8400, 0, 10, 0, "fp_10");
        step(0, 16'h8000, 0, 15, 0, "fp_15");
        step(0, 16'h0000, 0, -1, 0, "fp_idle");

        // Round-robin fairness: each owner drops for one cycle after grant
        step(0, 16'hFFFF, 1, 0, 0, "rr_start");
        for (int k = 1; k <= 16; k++)
            step(0, 16'hFFFF & ~(16'd1 << ((k - 1) % 16)), 1, k % 16, 0, "rr_order");
        step(0, 16'h0000, 1, -1, 0, "rr_idle");

        // Hold timeout; reset first so the pointer starts at 0
        step(1, 16'h0000, 1, -1, 0, "to_rst");
        step(0, 16'h0003, 1, 0, 0, "to_own0_first");
        for (int i = 0; i < 3; i++) step(0, 16'h0003, 1, 0, 0, "to_own0_hold");
        step(0, 16'h0003, 1, 1, 1, "to_preempt_1");
        for (int i = 0; i < 3; i++) step(0, 16'h0003, 1, 1, 0, "to_own1_hold");
        step(0, 16'h0003, 1, 0, 1, "to_preempt_0");
        for (int i = 0; i < 12; i++) step(0, 16'h0001, 1, 0, 0, "to_sole_owner");
        step(0, 16'h0000, 1, -1, 0, "to_idle");

        // Reset mid-grant clears the pointer
        step(0, 16'h0080, 0, 7, 0, "mid_grant7");
        step(0, 16'h0080, 0, 7, 0, "mid_hold7");
        step(1, 16'h0080, 0, -1, 0, "mid_rst");
        step(0, 16'h0180, 1, 7, 0, "mid_ptr_zero");
        step(0, 16'h0000, 1, -1, 0, "mid_idle");

        // Mode switch while busy takes effect only at arbitration
        step(0, 16'h0008, 1, 3, 0, "ms_grant3");
        step(0, 16'h8018, 0, 3, 0, "ms_hold3");
        step(0, 16'h8010, 0, 4, 0, "ms_fp4");
        step(0, 16'h0031, 1, 4, 0, "ms_hold4_rr");
        step(0, 16'h0021, 0, 0, 0, "ms_fp0");
        step(0, 16'h0000, 0, -1, 0, "ms_idle");

        repeat (2) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
